// File: rtl/alu8_seq_arb.sv
// Two-requester arbitrated ALU. One 4-bit slice processes each operand one nibble
// per cycle, least significant nibble first, and holds the result until it is taken.
module alu8_seq_arb #(
  parameter int NNIB    = 2,
  parameter int PRIO_RR = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  input  logic                req1_valid,
  output logic                req0_ready,
  output logic                req1_ready,
  input  logic [2:0]          req0_op,
  input  logic [2:0]          req1_op,
  input  logic [4*NNIB-1:0]   req0_a,
  input  logic [4*NNIB-1:0]   req0_b,
  input  logic [4*NNIB-1:0]   req1_a,
  input  logic [4*NNIB-1:0]   req1_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [4*NNIB-1:0]   rsp_data,
  output logic                rsp_cout,
  output logic                rsp_zero
);
  localparam int W  = 4*NNIB;
  localparam int CW = (NNIB > 1) ? $clog2(NNIB) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]    op_q;
  logic [W-1:0]  a_q, b_q, res_q;
  logic [CW-1:0] cnt_q;
  logic          id_q, carry_q, cout_q, zero_q, last_q;

  logic          gnt0, gnt1, accept, last_nib, arith, cin;
  logic [3:0]    x, y, nib;
  logic [4:0]    sum;
  logic [W+3:0]  shifted;

  // last_q = 1 means req1 was granted last, so req0 wins the next tie
  always_comb begin
    if (PRIO_RR != 0) gnt0 = req0_valid && (!req1_valid || last_q);
    else              gnt0 = req0_valid;
    gnt1 = req1_valid && !gnt0;
  end

  assign req0_ready = (state == IDLE) && !reset && gnt0;
  assign req1_ready = (state == IDLE) && !reset && gnt1;
  assign accept     = req0_ready || req1_ready;
  assign last_nib   = (cnt_q == CW'(NNIB-1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = EXEC;
      EXEC:    if (last_nib)  state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Nibble slice: operands shift right each cycle, result shifts in from the top
  always_comb begin
    arith = op_q inside {3'b001, 3'b010, 3'b011, 3'b100};
    x     = (op_q == 3'b001) ? ~a_q[3:0] : a_q[3:0];
    y     = (op_q == 3'b010) ? b_q[3:0] : (op_q == 3'b100) ? ~b_q[3:0] : 4'h0;
    cin   = (cnt_q == '0) ? (op_q inside {3'b001, 3'b011, 3'b100}) : carry_q;
    sum   = {1'b0, x} + {1'b0, y} + {4'b0, cin};
    case (op_q)
      3'b101:  nib = a_q[3:0] & b_q[3:0];
      3'b110:  nib = a_q[3:0] | b_q[3:0];
      3'b111:  nib = a_q[3:0] ^ b_q[3:0];
      default: nib = sum[3:0];
    endcase
    shifted = {nib, res_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= gnt0 ? req0_op : req1_op;
        a_q     <= gnt0 ? req0_a  : req1_a;
        b_q     <= gnt0 ? req0_b  : req1_b;
        id_q    <= gnt1;
        last_q  <= gnt1;
        cnt_q   <= '0;
        carry_q <= 1'b0;
      end
      if (state == EXEC) begin
        a_q     <= a_q >> 4;
        b_q     <= b_q >> 4;
        res_q   <= shifted[W+3:4];
        carry_q <= sum[4];
        cnt_q   <= last_nib ? '0 : cnt_q + CW'(1);
        if (last_nib) begin
          cout_q <= arith && sum[4];
          zero_q <= (shifted[W+3:4] == '0);
        end
      end
    end
  end

  assign rsp_valid = (state == DONE);
  assign rsp_id    = id_q;
  assign rsp_data  = res_q;
  assign rsp_cout  = cout_q;
  assign rsp_zero  = zero_q;
endmodule

// File: tb/tb_alu8_seq_arb.sv
// Scoreboard bench: expected results are queued at acceptance and compared when responses are taken.
module tb_alu8_seq_arb;
  localparam int NNIB = 2;
  localparam int W    = 4*NNIB;

  logic clk = 1'b0;
  logic reset;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_zero;
  logic [W-1:0] rsp_data;
  logic fp_r0, fp_r1, fp_valid, fp_id, fp_cout, fp_zero;
  logic [W-1:0] fp_data;
  logic fp_rdy = 1'b1;

  typedef struct packed {logic id; logic [W-1:0] data; logic cout; logic zero;} exp_t;
  exp_t exp_q[$];
  int   grants[$];
  int   errs = 0, checks = 0, fp_seen = 0;
  bit   fp_chk = 1'b0, rnd_mode = 1'b0;

  always #5 clk = ~clk;

  alu8_seq_arb #(.NNIB(NNIB), .PRIO_RR(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero));

  alu8_seq_arb #(.NNIB(NNIB), .PRIO_RR(0)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(fp_r0), .req1_ready(fp_r1),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(fp_valid), .rsp_ready(fp_rdy), .rsp_id(fp_id),
    .rsp_data(fp_data), .rsp_cout(fp_cout), .rsp_zero(fp_zero));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [2:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    exp_t e;
    case (op)
      3'd0: r = {1'b0, a};
      3'd1: r = {1'b0, ~a} + (W+1)'(1);
      3'd2: r = {1'b0, a} + {1'b0, b};
      3'd3: r = {1'b0, a} + (W+1)'(1);
      3'd4: r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      3'd5: r = {1'b0, a & b};
      3'd6: r = {1'b0, a | b};
      default: r = {1'b0, a ^ b};
    endcase
    e.id = id; e.data = r[W-1:0]; e.cout = r[W]; e.zero = (r[W-1:0] == '0);
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      chk("one_ready", {31'b0, req0_ready & req1_ready}, 0);
      if (req0_valid && req0_ready) begin
        exp_q.push_back(model(1'b0, req0_op, req0_a, req0_b)); grants.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back(model(1'b1, req1_op, req1_a, req1_b)); grants.push_back(1);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
          chk("rsp_data", {24'b0, rsp_data}, {24'b0, e.data});
          chk("rsp_cout", {31'b0, rsp_cout}, {31'b0, e.cout});
          chk("rsp_zero", {31'b0, rsp_zero}, {31'b0, e.zero});
        end
      end
      if (fp_chk && fp_valid) begin
        e = model(1'b0, req0_op, req0_a, req0_b);
        fp_seen++;
        chk("fp_id", {31'b0, fp_id}, 0);
        chk("fp_data", {24'b0, fp_data}, {24'b0, e.data});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_mode) rsp_ready = 1'($urandom_range(0, 1));
  end

  task automatic wait_ready(input int idx);
    int n = 0;
    @(negedge clk);
    while (!(idx == 0 ? req0_ready : req1_ready) && n < 60) begin n++; @(negedge clk); end
    chk("accept_timeout", {31'b0, n < 60}, 1);
  endtask

  task automatic wait_rsp();
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 60) begin n++; @(negedge clk); end
    chk("rsp_timeout", {31'b0, n < 60}, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
    chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Operands are scrambled right after acceptance to prove the DUT uses its captured copy
  task automatic send(input int idx, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    if (idx == 0) begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    else          begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    wait_ready(idx);
    @(posedge clk); #1;
    if (idx == 0) begin req0_valid = 0; req0_op = 3'($urandom); req0_a = W'($urandom); req0_b = W'($urandom); end
    else          begin req1_valid = 0; req1_op = 3'($urandom); req1_a = W'($urandom); req1_b = W'($urandom); end
  endtask

  task automatic expect_rsp(input string tag, input logic [W-1:0] d, input logic c, input logic z);
    wait_rsp();
    chk({tag, "_data"}, {24'b0, rsp_data}, {24'b0, d});
    chk({tag, "_cout"}, {31'b0, rsp_cout}, {31'b0, c});
    chk({tag, "_zero"}, {31'b0, rsp_zero}, {31'b0, z});
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1; exp_q.delete(); grants.delete();
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t sd;
    int n;
    reset = 1; rsp_ready = 1;
    req0_valid = 1; req1_valid = 1; req0_op = 3'd2; req1_op = 3'd2;
    req0_a = 8'h11; req0_b = 8'h22; req1_a = 8'h33; req1_b = 8'h44;
    @(negedge clk);
    chk("rst_r0", {31'b0, req0_ready}, 0);
    chk("rst_r1", {31'b0, req1_ready}, 0);
    chk("rst_valid", {31'b0, rsp_valid}, 0);
    chk("rst_data", {24'b0, rsp_data}, 0);
    chk("rst_cout", {31'b0, rsp_cout}, 0);
    chk("rst_zero", {31'b0, rsp_zero}, 0);
    chk("rst_id", {31'b0, rsp_id}, 0);
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1; reset = 0;

    // ADD with exact latency and post-accept operand change
    @(posedge clk); #1;
    req0_valid = 1; req0_op = 3'b010; req0_a = 8'h7F; req0_b = 8'h01;
    wait_ready(0);
    @(posedge clk); #1;
    req0_valid = 0; req0_op = 3'b111; req0_a = 8'h00; req0_b = 8'hAA;
    @(negedge clk); chk("lat_t1", {31'b0, rsp_valid}, 0);
    @(negedge clk); chk("lat_t2", {31'b0, rsp_valid}, 0);
    @(negedge clk); chk("lat_t3", {31'b0, rsp_valid}, 1);
    chk("add_data", {24'b0, rsp_data}, 32'h80);
    chk("add_cout", {31'b0, rsp_cout}, 0);
    chk("add_zero", {31'b0, rsp_zero}, 0);
    chk("add_id", {31'b0, rsp_id}, 0);
    drain();

    send(0, 3'b100, 8'h05, 8'h05); expect_rsp("sub", 8'h00, 1'b1, 1'b1);
    send(1, 3'b001, 8'h01, 8'h00); expect_rsp("neg", 8'hFF, 1'b0, 1'b0);
    send(0, 3'b011, 8'hFF, 8'h00); expect_rsp("inc", 8'h00, 1'b1, 1'b1);
    send(1, 3'b111, 8'hF0, 8'hFF); expect_rsp("xor", 8'h0F, 1'b0, 1'b0);
    send(0, 3'b000, 8'hA5, 8'h3C); expect_rsp("pass", 8'hA5, 1'b0, 1'b0);
    send(0, 3'b101, 8'hF0, 8'h3C); expect_rsp("and", 8'h30, 1'b0, 1'b0);
    drain();

    // Response stall: outputs frozen, no accepts, then handshake
    rsp_ready = 0;
    send(0, 3'b010, 8'h12, 8'h34);
    req1_valid = 1; req1_op = 3'b110; req1_a = 8'h0F; req1_b = 8'hF0;
    wait_rsp();
    sd.id = rsp_id; sd.data = rsp_data; sd.cout = rsp_cout; sd.zero = rsp_zero;
    chk("stall_first", {24'b0, rsp_data}, 32'h46);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, rsp_valid}, 1);
      chk("stall_data", {24'b0, rsp_data}, {24'b0, sd.data});
      chk("stall_flags", {29'b0, rsp_id, rsp_cout, rsp_zero}, {29'b0, sd.id, sd.cout, sd.zero});
      chk("stall_r0", {31'b0, req0_ready}, 0);
      chk("stall_r1", {31'b0, req1_ready}, 0);
    end
    @(posedge clk); #1; rsp_ready = 1;
    @(negedge clk); chk("hs_r1", {31'b0, req1_ready}, 0);
    @(negedge clk); chk("post_hs_r1", {31'b0, req1_ready}, 1);
    @(posedge clk); #1; req1_valid = 0;
    drain();

    // Reset during EXEC discards the op
    send(1, 3'b010, 8'h40, 8'h02);
    reset = 1; req0_valid = 1; req1_valid = 1;
    req0_op = 3'b100; req0_a = 8'h10; req0_b = 8'h01;
    req1_op = 3'b010; req1_a = 8'h01; req1_b = 8'h01;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mid_rst_r0", {31'b0, req0_ready}, 0);
      chk("mid_rst_r1", {31'b0, req1_ready}, 0);
      chk("mid_rst_valid", {31'b0, rsp_valid}, 0);
    end
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    chk("post_rst_r0", {31'b0, req0_ready}, 1);
    chk("post_rst_r1", {31'b0, req1_ready}, 0);
    chk("post_rst_valid", {31'b0, rsp_valid}, 0);
    @(posedge clk); #1; req0_valid = 0; req1_valid = 0;
    drain();

    // Continuous contention: RR alternates, fixed priority always serves req0
    pulse_reset();
    fp_chk = 1; fp_seen = 0;
    req0_valid = 1; req0_op = 3'b010; req0_a = 8'h10; req0_b = 8'h22;
    req1_valid = 1; req1_op = 3'b011; req1_a = 8'h33; req1_b = 8'h00;
    n = 0;
    while (grants.size() < 4 && n < 200) begin @(negedge clk); n++; end
    chk("rr_timeout", {31'b0, n < 200}, 1);
    @(posedge clk); #1; req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 4; i++) chk("rr_grant", grants[i], i % 2);
    drain();
    repeat (4) @(negedge clk);
    fp_chk = 0;
    chk("fp_count", {31'b0, fp_seen >= 3}, 1);

    // Random traffic with random back-pressure
    rnd_mode = 1;
    for (int i = 0; i < 16; i++)
      send(int'($urandom_range(0, 1)), 3'($urandom), W'($urandom), W'($urandom));
    drain();
    rnd_mode = 0; rsp_ready = 1;
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alu8_seq_arb.md
ALU8_SEQ_ARB -- requirements
Module: alu8_seq_arb

Interface
REQ-001 SHALL have parameter NNIB, default 2, number of 4-bit nibbles per operand (operand width W = 4*NNIB).
REQ-002 SHALL have parameter PRIO_RR, default 1, arbitration mode (1 = round-robin, 0 = fixed priority, req0 highest).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0_valid, req1_valid  input  1 each  requester has an operation pending.
REQ-006 req0_ready, req1_ready  output  1 each  requester's operation accepted this cycle when ready & valid.
REQ-007 req0_op, req1_op  input  3 each  operation code.
REQ-008 req0_a, req0_b, req1_a, req1_b  input  W each  operands.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes result when valid & ready.
REQ-011 rsp_id  output  1  requester index (0/1) of the result.
REQ-012 rsp_data  output  W  result; rsp_cout output 1 carry-out; rsp_zero output 1 result == 0.

Function
REQ-013 Ops SHALL be: 000 pass A; 001 negate A (~A+1); 010 A+B; 011 A+1; 100 A-B (A+~B+1); 101 A AND B; 110 A OR B; 111 A XOR B.
REQ-014 Execution SHALL be nibble-serial through one internal 4-bit adder/logic slice, one nibble per cycle, least significant first.
REQ-015 Per nibble: x = ~A_nib for 001, else A_nib; y = B_nib for 010, ~B_nib for 100, else 0; carry-in of nibble 0 = 1 for 001/011/100, else 0; later nibbles use the registered carry of the previous nibble.
REQ-016 rsp_cout SHALL be the carry out of the top nibble for ops 001-100 and 0 for 000 and 101-111; rsp_zero SHALL be 1 iff rsp_data == 0.
REQ-017 FSM states SHALL be IDLE, EXEC, DONE; IDLE->EXEC on accept; EXEC holds NNIB cycles (nibble counter 0..NNIB-1) then ->DONE; DONE->IDLE on rsp_valid & rsp_ready.
REQ-018 req_ready SHALL be asserted only in IDLE and only to the granted requester; at most one ready asserted per cycle.
REQ-019 Round-robin: with one valid requester grant it; with both valid grant the one not granted last; after reset req1 is treated as last granted (req0 wins first tie).
REQ-020 Fixed priority (PRIO_RR=0): req0 SHALL win whenever req0_valid.
REQ-021 Op, operands and requester index SHALL be captured at acceptance; later changes on request inputs SHALL not affect the operation.
REQ-022 Latency: accept in cycle t -> rsp_valid first high in cycle t+NNIB+1.
REQ-023 rsp_valid SHALL be high only in DONE; rsp_data, rsp_cout, rsp_zero, rsp_id SHALL stay stable while rsp_valid & !rsp_ready.
REQ-024 No new request SHALL be accepted in the rsp handshake cycle; earliest next accept is the following cycle (IDLE).
REQ-025 Arithmetic SHALL wrap modulo 2^W; no overflow flag.

Reset
REQ-026 reset SHALL immediately force IDLE, nibble counter 0, carry 0, rsp_valid 0, req0_ready/req1_ready 0 while reset high, rsp_data 0, rsp_cout 0, rsp_zero 0, rsp_id 0, round-robin pointer as in REQ-019.
REQ-027 reset mid-operation SHALL discard the in-flight operation with no response produced.

Verification
REQ-028 req0: op=010 A=0x7F B=0x01, rsp_ready=1 -> rsp_data=0x80, cout=0, zero=0, rsp_id=0, rsp_valid exactly 3 cycles after accept (NNIB=2).
REQ-029 op=100 A=0x05 B=0x05 -> 0x00, cout=1, zero=1; op=001 A=0x01 -> 0xFF, cout=0; op=011 A=0xFF -> 0x00, cout=1, zero=1; op=111 A=0xF0 B=0xFF -> 0x0F, cout=0.
REQ-030 Both requesters valid continuously, PRIO_RR=1 -> grants 0,1,0,1; rsp_id alternates; with PRIO_RR=0 -> all grants to req0.
REQ-031 rsp_ready low 5 cycles in DONE -> rsp outputs stable, both req_ready 0; rsp_ready high -> IDLE next cycle, accept no earlier than cycle after handshake.
REQ-032 reset pulsed during EXEC -> rsp_valid never asserts for that op; both readies 0 during reset; next simultaneous request after reset granted to req0 and completes correctly.
REQ-033 Operands changed on req0 inputs the cycle after accept -> result reflects captured values only.
